// File: rtl/operand_fifo.sv
// operand_fifo: operand-pair buffer in front of the tt_um_processor datapath.
// Captures (A,B) pairs from the pins (ui_in -> A, uio_in -> B) into a small FIFO
// and presents the head to the execute stage with a valid/ready handshake.
// The pins cannot be stalled, so a pair offered while full is dropped and the
// sticky overflow flag is raised.
//
// Optional build macro OPERAND_FIFO_CLR_EN adds a synchronous flush input clr.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        design enable; all state holds when low
//   clr        (OPERAND_FIFO_CLR_EN only) flush pointers, count and overflow
//   in_valid   pair offered this cycle
//   in_a/in_b  offered operands
//   in_ready   FIFO not full
//   out_valid  head entry available
//   out_a/out_b head operands, forced to 0 when empty
//   out_ready  downstream consumes head this cycle
//   count      stored entries, 0..DEPTH
//   overflow   sticky: a pair was dropped
module operand_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
`ifdef OPERAND_FIFO_CLR_EN
  input  logic              clr,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic flush, push, pop, drop;

`ifdef OPERAND_FIFO_CLR_EN
  assign flush = ena & clr;
`else
  assign flush = 1'b0;
`endif

  // Status depends on the registered count only, never on this cycle's pop.
  assign in_ready  = (count_q != FullCnt);
  assign out_valid = (count_q != '0);

  assign push = ena & in_valid & in_ready & ~flush;
  assign pop  = ena & out_valid & out_ready & ~flush;
  assign drop = ena & in_valid & ~in_ready & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared by reset only; a flush leaves it, as out_* are masked when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  assign out_a    = out_valid ? mem_a_q[rd_ptr_q] : '0;
  assign out_b    = out_valid ? mem_b_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_operand_fifo.sv
// Self-checking bench for operand_fifo. A scoreboard queue holds the pairs the
// bench expects the FIFO to contain; the head is compared whenever a pop is driven.
module tb_operand_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sb [$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  operand_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
`ifdef OPERAND_FIFO_CLR_EN
    .clr      (clr),
`endif
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
  );

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic tick(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, input logic en, input logic cl);
    bit do_push, do_pop, do_drop, do_clr;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    ena       = en;
    clr       = cl;
`ifdef OPERAND_FIFO_CLR_EN
    do_clr = en && cl;
`else
    do_clr = 1'b0;
`endif
    do_push = !do_clr && en && iv && (sb.size() < DEPTH);
    do_drop = !do_clr && en && iv && (sb.size() == DEPTH);
    do_pop  = !do_clr && en && ordy && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (do_clr) begin
      sb.delete();
      m_ovf = 1'b0;
    end
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back({a, b});
    if (do_drop) m_ovf = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00 || in_ready !== 1'b1 ||
        count !== 3'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got v=%b a=%h b=%h rdy=%b cnt=%0d ovf=%b, want 0 00 00 1 0 0",
               out_valid, out_a, out_b, in_ready, count, overflow);
    end
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_push();
    tick(1'b1, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_a !== 8'd3 || out_b !== 8'd2 || count !== 3'd1 ||
        in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_push: got v=%b a=%0d b=%0d cnt=%0d rdy=%b, want 1 3 2 1 1",
               out_valid, out_a, out_b, count, in_ready);
    end
    n_vec++;
    if ({out_a, out_b} !== sb[0]) begin
      n_err++;
      $display("FAIL single_pop: got %h want %h", {out_a, out_b}, sb[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_fill_order();
    logic [7:0] va [4] = '{8'd3, 8'd1, 8'd5, 8'd7};
    logic [7:0] vb [4] = '{8'd2, 8'd4, 8'd3, 8'd2};
    for (int i = 0; i < 4; i++) tick(1'b1, va[i], vb[i], 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill: got cnt=%0d rdy=%b, want 4 0", count, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || {out_a, out_b} !== sb[0]) begin
        n_err++;
        $display("FAIL fill_order[%0d]: got v=%b %h want 1 %h", i, out_valid, {out_a, out_b},
                 sb[0]);
      end
      tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    end
    n_vec++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_a !== 8'd0 || out_b !== 8'd0) begin
      n_err++;
      $display("FAIL drained: got cnt=%0d v=%b a=%h b=%h, want 0 0 00 00",
               count, out_valid, out_a, out_b);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(i + 10), 8'(i + 20), 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (overflow !== m_ovf || count !== 3'(sb.size()) || {out_a, out_b} !== sb[0]) begin
      n_err++;
      $display("FAIL overflow: got ovf=%b cnt=%0d head=%h, want %b %0d %h",
               overflow, count, {out_a, out_b}, m_ovf, sb.size(), sb[0]);
    end
    // Pop while full and offer a pair: the offer is still dropped.
    n_vec++;
    if ({out_a, out_b} !== sb[0]) begin
      n_err++;
      $display("FAIL full_pop_head: got %h want %h", {out_a, out_b}, sb[0]);
    end
    tick(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      n_vec++;
      if ({out_a, out_b} !== sb[0]) begin
        n_err++;
        $display("FAIL ovf_drain: got %h want %h", {out_a, out_b}, sb[0]);
      end
      tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    end
    n_vec++;
    if (overflow !== 1'b1 || count !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d, want 1 0", overflow, count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(1'b1, 8'd8, 8'd9, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'd6, 8'd5, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({out_a, out_b} !== sb[0]) begin
      n_err++;
      $display("FAIL simul_head: got %h want %h", {out_a, out_b}, sb[0]);
    end
    tick(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (count !== 3'd2 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL simul_count: got cnt=%0d ovf=%b, want 2 0", count, overflow);
    end
    while (sb.size() > 0) begin
      n_vec++;
      if ({out_a, out_b} !== sb[0]) begin
        n_err++;
        $display("FAIL simul_drain: got %h want %h", {out_a, out_b}, sb[0]);
      end
      tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap_ena();
    logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (sb.size() > 0) begin
        n_vec++;
        if ({out_a, out_b} !== sb[0]) begin
          n_err++;
          $display("FAIL wrap[%0d]: got %h want %h", i, {out_a, out_b}, sb[0]);
        end
      end
      tick(1'b1, a, b, (i >= 2), 1'b1, 1'b0);
    end
    while (sb.size() > 0) begin
      n_vec++;
      if ({out_a, out_b} !== sb[0]) begin
        n_err++;
        $display("FAIL wrap_drain: got %h want %h", {out_a, out_b}, sb[0]);
      end
      tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    end
    tick(1'b1, 8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (count !== 3'(sb.size()) || out_valid !== 1'b1 || {out_a, out_b} !== sb[0]) begin
        n_err++;
        $display("FAIL ena_hold[%0d]: got cnt=%0d v=%b %h, want %0d 1 %h",
                 i, count, out_valid, {out_a, out_b}, sb.size(), sb[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(i + 1), 8'(i + 2), 1'b0, 1'b1, 1'b0);
    // Between edges: the next rising edge is 9 ns away.
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_a !== 8'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b cnt=%0d a=%h rdy=%b, want 0 0 00 1",
               out_valid, count, out_a, in_ready);
    end
    #2;
    rst_n = 1'b1;
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef OPERAND_FIFO_CLR_EN
  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(i), 8'(i), 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_setup: got cnt=%0d ovf=%b, want 3 1", count, overflow);
    end
    tick(1'b1, 8'h77, 8'h77, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (count !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || out_a !== 8'd0) begin
      n_err++;
      $display("FAIL clr: got cnt=%0d ovf=%b v=%b a=%h, want 0 0 0 00",
               count, overflow, out_valid, out_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill_order();
    test_overflow();
    test_simultaneous();
    test_wrap_ena();
    test_reset_mid();
`ifdef OPERAND_FIFO_CLR_EN
    test_clr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
